// File: rtl/sar_adc_scan.sv
// Successive-approximation ADC controller: single-channel or round-robin scan, start/busy/eoc handshake.
// Optional build macro SAR_AVG_EN: averages 2^AVG_LOG2 conversions per reported result.
module sar_adc_scan #(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 4,
  parameter int CLK_DIV      = 4,
  parameter int SETTLE_TICKS = 2,
  parameter int AVG_LOG2     = 2,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             scan,
  input  logic             stop,
  input  logic [CH_W-1:0]  ch_sel,
  input  logic             ecmp,
  output logic             busy,
  output logic             eoc,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic [WIDTH-1:0] dac_code,
  output logic             sample,
  output logic [CH_W-1:0]  mux_ch
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} sarState_t;

  sarState_t        state;
  logic [PW-1:0]    prescale;
  logic             tick;
  logic             ecmpMeta, ecmpSync;
  logic             scanLatch, stopFlag;
  logic [SW-1:0]    settleCnt;
  logic [BW-1:0]    bitIdx;
  logic [WIDTH-1:0] acc, mask, accNext;
  logic [CH_W-1:0]  chNext;
  logic             chOk;

`ifdef SAR_AVG_EN
  localparam int SUM_W = WIDTH + AVG_LOG2;
  localparam int AW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  logic [SUM_W-1:0] sum;
  logic [AW-1:0]    avgCnt;
  logic             lastAvg;
  assign lastAvg = (avgCnt == AW'((1 << AVG_LOG2) - 1));
`endif

  assign tick    = (prescale == PW'(CLK_DIV - 1));
  assign mask    = WIDTH'(1) << bitIdx;
  assign accNext = ecmpSync ? (acc | mask) : acc;
  assign chNext  = (mux_ch == CH_W'(CHANNELS - 1)) ? '0 : mux_ch + CH_W'(1);
  assign chOk    = ({1'b0, ch_sel} < (CH_W + 1)'(CHANNELS));

  // Comparator is asynchronous to the trial timing; only the second flop is used.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ecmpMeta <= 1'b0;
      ecmpSync <= 1'b0;
    end else begin
      ecmpMeta <= ecmp;
      ecmpSync <= ecmpMeta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   prescale <= '0;
    else if (state == SAMPLE || state == CONVERT) prescale <= tick ? '0 : prescale + PW'(1);
    else                                         prescale <= '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      eoc       <= 1'b0;
      sample    <= 1'b0;
      result    <= '0;
      result_ch <= '0;
      dac_code  <= '0;
      mux_ch    <= '0;
      scanLatch <= 1'b0;
      stopFlag  <= 1'b0;
      settleCnt <= '0;
      bitIdx    <= '0;
      acc       <= '0;
`ifdef SAR_AVG_EN
      sum       <= '0;
      avgCnt    <= '0;
`endif
    end else begin
      eoc <= 1'b0;
      if (busy && stop) stopFlag <= 1'b1;
      case (state)
        IDLE: if (start) begin
          scanLatch <= scan;
          mux_ch    <= chOk ? ch_sel : '0;
          busy      <= 1'b1;
          sample    <= 1'b1;
          dac_code  <= '0;
          settleCnt <= '0;
          state     <= SAMPLE;
        end
        SAMPLE: if (tick) begin
          if (settleCnt == SW'(SETTLE_TICKS - 1)) begin
            sample   <= 1'b0;
            acc      <= '0;
            bitIdx   <= BW'(WIDTH - 1);
            dac_code <= WIDTH'(1) << (WIDTH - 1);
            state    <= CONVERT;
          end else begin
            settleCnt <= settleCnt + SW'(1);
          end
        end
        CONVERT: if (tick) begin
          acc <= accNext;
          if (bitIdx == '0) begin
            dac_code <= '0;
`ifdef SAR_AVG_EN
            // Intermediate conversions fold into the sum and resample without a DONE cycle.
            if (!lastAvg) begin
              sum       <= sum + SUM_W'(accNext);
              avgCnt    <= avgCnt + AW'(1);
              sample    <= 1'b1;
              settleCnt <= '0;
              state     <= SAMPLE;
            end else begin
              state <= DONE;
            end
`else
            state <= DONE;
`endif
          end else begin
            bitIdx   <= bitIdx - BW'(1);
            dac_code <= accNext | (mask >> 1);
          end
        end
        DONE: begin
`ifdef SAR_AVG_EN
          result <= WIDTH'((sum + SUM_W'(acc)) >> AVG_LOG2);
          sum    <= '0;
          avgCnt <= '0;
`else
          result <= acc;
`endif
          result_ch <= mux_ch;
          eoc       <= 1'b1;
          dac_code  <= '0;
          if (scanLatch && !(stopFlag || stop)) begin
            mux_ch    <= chNext;
            sample    <= 1'b1;
            settleCnt <= '0;
            state     <= SAMPLE;
          end else begin
            busy     <= 1'b0;
            stopFlag <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_scan.sv
// Bench for sar_adc_scan (default build): ideal comparator model, eoc-driven scoreboard, latency/handshake sequences.
module tb_sar_adc_scan;
  logic       clock = 1'b0, reset = 1'b1, start = 1'b0, scan = 1'b0, stop = 1'b0;
  logic [1:0] ch_sel = '0;
  logic       ecmp;
  logic       busy, eoc, sample;
  logic [7:0] result, dac_code;
  logic [1:0] result_ch, mux_ch;
  logic [7:0] vinTab [4];

  sar_adc_scan dut (
    .clock(clock), .reset(reset), .start(start), .scan(scan), .stop(stop), .ch_sel(ch_sel),
    .ecmp(ecmp), .busy(busy), .eoc(eoc), .result(result), .result_ch(result_ch),
    .dac_code(dac_code), .sample(sample), .mux_ch(mux_ch)
  );

  assign ecmp = (vinTab[mux_ch] >= dac_code);
  always #5 clock = ~clock;

  typedef struct { logic [7:0] vin; logic [1:0] ch; logic [7:0] expRes; } vec_t;
  typedef struct { logic [7:0] res; logic [1:0] ch; } exp_t;
  exp_t sbq[$];
  int compared = 0, mismatched = 0, eocCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset && eoc === 1'b1) begin
      eocCount++;
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_eoc: result=0x%0h ch=%0d with nothing expected", result, result_ch);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("result_ch", result_ch, e.ch);
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic pulseStart(input logic [1:0] ch, input logic sc);
    @(negedge clock); ch_sel = ch; scan = sc; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
  endtask

  task automatic waitEoc(input int limit, output int n);
    n = 0;
    while (eoc !== 1'b1 && n < limit) begin step(); n++; end
    if (eoc !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL eoc_timeout: no eoc within %0d cycles", limit);
    end
  endtask

  initial begin
    vec_t vt[7];
    int n, m, e0;
    logic [7:0] expDac;
    vt[0] = '{8'hA5, 2'd2, 8'hA5};
    vt[1] = '{8'h00, 2'd1, 8'h00};
    vt[2] = '{8'hFF, 2'd0, 8'hFF};
    vt[3] = '{8'h01, 2'd3, 8'h01};
    vt[4] = '{8'h80, 2'd2, 8'h80};
    vt[5] = '{8'h7F, 2'd1, 8'h7F};
    vt[6] = '{8'h3C, 2'd0, 8'h3C};
    for (int i = 0; i < 4; i++) vinTab[i] = 8'h00;

    repeat (3) @(posedge clock); #1;
    check("rst_busy", busy, 0);     check("rst_eoc", eoc, 0);
    check("rst_sample", sample, 0); check("rst_result", result, 0);
    check("rst_result_ch", result_ch, 0);
    check("rst_dac", dac_code, 0);  check("rst_mux", mux_ch, 0);
    @(negedge clock) reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      vinTab[vt[i].ch] = vt[i].vin;
      sbq.push_back(exp_t'{vt[i].expRes, vt[i].ch});
      pulseStart(vt[i].ch, 1'b0);
      check("busy_accept", busy, 1);
      check("mux_select", mux_ch, vt[i].ch);
      waitEoc(100, n);
      check("latency", n, 41);
      step();
      check("busy_fall", busy, 0);
    end

    // Full-scale input: every trial keeps its bit, code climbs 0x80, 0xC0, ... 0xFF.
    vinTab[0] = 8'hFF;
    sbq.push_back(exp_t'{8'hFF, 2'd0});
    pulseStart(2'd0, 1'b0);
    check("sample_track", sample, 1);
    check("dac_in_sample", dac_code, 0);
    n = 0;
    for (int b = 0; b < 8; b++) begin
      expDac = 8'hFF << (7 - b);
      while (n < 8 + 4 * b) begin step(); n++; end
      check("dac_step_first", dac_code, expDac);
      if (b == 0) check("sample_hold", sample, 0);
      while (n < 11 + 4 * b) begin step(); n++; end
      check("dac_step_held", dac_code, expDac);
    end
    waitEoc(20, m);
    check("latency_ff", n + m, 41);
    check("dac_done", dac_code, 0);
    step();

    // Scan from ch3, stop during the sixth conversion.
    vinTab[0] = 8'd10; vinTab[1] = 8'd20; vinTab[2] = 8'd30; vinTab[3] = 8'd40;
    sbq.push_back(exp_t'{8'd40, 2'd3}); sbq.push_back(exp_t'{8'd10, 2'd0});
    sbq.push_back(exp_t'{8'd20, 2'd1}); sbq.push_back(exp_t'{8'd30, 2'd2});
    sbq.push_back(exp_t'{8'd40, 2'd3}); sbq.push_back(exp_t'{8'd10, 2'd0});
    e0 = eocCount;
    pulseStart(2'd3, 1'b1);
    scan = 1'b0;
    n = 0;
    while (n < 219) begin step(); n++; end
    check("scan_busy_mid", busy, 1);
    @(negedge clock) stop = 1'b1;
    step(); stop = 1'b0; n++;
    while (sbq.size() != 0 && n < 400) begin step(); n++; end
    check("scan_drained", sbq.size(), 0);
    step();
    check("scan_busy_fall", busy, 0);
    repeat (100) step();
    check("scan_eoc_count", eocCount - e0, 6);
    check("scan_idle", busy, 0);
    sbq.delete();

    // Reset mid-conversion.
    vinTab[1] = 8'h77;
    pulseStart(2'd1, 1'b0);
    repeat (20) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);     check("abort_sample", sample, 0);
    check("abort_dac", dac_code, 0);  check("abort_result", result, 0);
    check("abort_mux", mux_ch, 0);    check("abort_eoc", eoc, 0);
    @(negedge clock) reset = 1'b0;
    e0 = eocCount;
    repeat (60) step();
    check("abort_no_eoc", eocCount - e0, 0);
    vinTab[2] = 8'h3C;
    sbq.push_back(exp_t'{8'h3C, 2'd2});
    pulseStart(2'd2, 1'b0);
    waitEoc(100, n);
    check("latency_after_abort", n, 41);
    step();

    // Start while busy is dropped; a later start from IDLE is accepted.
    vinTab[3] = 8'h5A;
    sbq.push_back(exp_t'{8'h5A, 2'd3});
    e0 = eocCount;
    pulseStart(2'd3, 1'b0);
    n = 0;
    repeat (9) begin step(); n++; end
    @(negedge clock) start = 1'b1;
    step(); start = 1'b0; n++;
    waitEoc(100, m);
    check("latency_ignore", n + m, 41);
    repeat (60) step();
    check("ignore_eoc_count", eocCount - e0, 1);
    check("ignore_idle", busy, 0);
    sbq.push_back(exp_t'{8'h5A, 2'd3});
    pulseStart(2'd3, 1'b0);
    check("idle_accept", busy, 1);
    waitEoc(100, n);
    step();

    // start held high retriggers right after DONE.
    vinTab[0] = 8'hC3;
    sbq.push_back(exp_t'{8'hC3, 2'd0});
    sbq.push_back(exp_t'{8'hC3, 2'd0});
    @(negedge clock) ch_sel = 2'd0; scan = 1'b0; start = 1'b1;
    step();
    waitEoc(100, n);
    check("latency_held", n, 41);
    step();
    check("retrigger_busy", busy, 1);
    start = 1'b0;
    waitEoc(100, n);
    check("latency_retrigger", n, 41);
    step();
    check("retrigger_fall", busy, 0);
    repeat (5) step();
    check("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
